// File: rtl/pci_target32_wbuf.sv
// PCI target backend: single-BAR decode, posted-write FIFO and per-phase completion status.
// Reads are never served here; every claimed read is retried.
module pci_target32_wbuf #(
   parameter logic [31:0] BAR_BASE = 32'h1000_0000,
   parameter logic [31:0] BAR_MASK = 32'hFFFF_0000,
   parameter int          DEPTH    = 8,
   parameter int          AW       = 3
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [31:0] address_i,
   input  logic [3:0]  bc_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  be_i,
   input  logic        req_i,
   input  logic        rdy_i,
   input  logic        last_i,
   output logic        addr_claim_o,
   output logic [3:0]  status_o,
   input  logic        fifo_rd_i,
   output logic        fifo_empty_o,
   output logic [3:0]  fifo_bc_o,
   output logic [3:0]  fifo_be_o,
   output logic [31:0] fifo_addr_o,
   output logic [31:0] fifo_data_o
);

   // state | meaning
   // IDLE  | waiting for a claimed request
   // XFER  | write burst accepted, posting data phases
   // TERM  | termination signalled, waiting for req_i to drop
   typedef enum logic [1:0] {IDLE, XFER, TERM} state_t;

   localparam logic [3:0] ST_WAIT   = 4'd0;
   localparam logic [3:0] ST_XFERED = 4'd1;
   localparam logic [3:0] ST_RETRY  = 4'd2;
   localparam logic [3:0] ST_DWO    = 4'd3;
   localparam logic [3:0] ST_DW     = 4'd4;
   localparam logic [3:0] ST_TABORT = 4'd5;

   localparam logic [AW:0] FULL_C     = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_LEFT_C = (AW+1)'(DEPTH - 1);

   state_t          state_q, state_d;
   logic [AW:0]     count_q, count_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [71:0]     mem_q [DEPTH];

   logic            claim;
   logic            is_write;
   logic            is_io_write;
   logic            full;
   logic            one_left;
   logic            push;
   logic            pop;
   logic [3:0]      status_c;
   logic [71:0]     head;

   assign claim        = req_i & ((address_i & BAR_MASK) == (BAR_BASE & BAR_MASK));
   assign addr_claim_o = claim;
   assign is_io_write  = (bc_i == 4'b0011);
   assign is_write     = (bc_i == 4'b0111) | (bc_i == 4'b1111) | is_io_write;
   assign full         = (count_q == FULL_C);
   assign one_left     = (count_q == ONE_LEFT_C);
   assign fifo_empty_o = (count_q == '0);
   assign pop          = fifo_rd_i & ~fifo_empty_o;

   always_comb begin
      state_d  = state_q;
      status_c = ST_WAIT;
      push     = 1'b0;
      case (state_q)
         IDLE: begin
            if (claim) begin
               if (!is_write || full) begin
                  status_c = ST_RETRY;
                  state_d  = TERM;
               end else begin
                  state_d  = XFER;
               end
            end
         end
         XFER: begin
            if (!req_i) begin
               state_d = IDLE;
            end else if (rdy_i) begin
               if (!claim) begin
                  status_c = ST_TABORT;
                  state_d  = TERM;
               end else if (full) begin
                  status_c = ST_DWO;
                  state_d  = TERM;
               end else begin
                  push = 1'b1;
                  // last_i wins: a final phase completes normally even into the last slot
                  if (last_i) begin
                     status_c = ST_XFERED;
                     state_d  = TERM;
                  end else if (one_left || is_io_write) begin
                     status_c = ST_DW;
                     state_d  = TERM;
                  end else begin
                     status_c = ST_XFERED;
                  end
               end
            end
         end
         TERM: begin
            if (!req_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign status_o = reset_in ? ST_WAIT : status_c;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q  <= IDLE;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) mem_q[wr_ptr_q] <= {bc_i, be_i, address_i, data_i};
   end

   assign head        = fifo_empty_o ? 72'd0 : mem_q[rd_ptr_q];
   assign fifo_bc_o   = head[71:68];
   assign fifo_be_o   = head[67:64];
   assign fifo_addr_o = head[63:32];
   assign fifo_data_o = head[31:0];

endmodule

// File: doc/pci_target32_wbuf.md
# pci_target32_wbuf

Backend stage directly downstream of `pci_target32_sm`. It decodes the target's current address against one memory/IO BAR and drives `addr_claim`. It posts write data phases into a small first-word-fall-through FIFO and returns a per-phase completion status. The application side drains that FIFO. Reads are never served here; every claimed read is retried.

## Interface
- `BAR_BASE`, default 32'h1000_0000: base address compared after masking.
- `BAR_MASK`, default 32'hFFFF_0000: address bits that participate in decode.
- `DEPTH`, default 8: FIFO entries; power of 2, minimum 2.
- `AW`, default 3: log2(DEPTH).
- `clk_in`, in, 1: the single clock.
- `reset_in`, in, 1: asynchronous, active-high reset.
- `address_i`, in, 32: current phase address from the target SM.
- `bc_i`, in, 4: latched PCI bus command.
- `data_i`, in, 32: write data.
- `be_i`, in, 4: active-low byte enables.
- `req_i`, in, 1: transaction request.
- `rdy_i`, in, 1: data phase valid.
- `last_i`, in, 1: last data phase.
- `addr_claim_o`, out, 1: address decode hit.
- `status_o`, out, 4: completion status, using the codes in `pci_stat.v`:
  - WAIT = 0
  - TRANSFERED = 1
  - RETRY = 2
  - DISCONNECT_WO_DATA = 3
  - DISCONNECT_W_DATA = 4
  - TABORT = 5
- `fifo_rd_i`, in, 1: pop the head entry; ignored when the FIFO is empty.
- `fifo_empty_o`, out, 1: FIFO holds no entries.
- `fifo_bc_o`, out, 4: head entry bus command.
- `fifo_be_o`, out, 4: head entry byte enables.
- `fifo_addr_o`, out, 32: head entry address.
- `fifo_data_o`, out, 32: head entry data.

## Operation
- Decode is combinational: `addr_claim_o = req_i & ((address_i & BAR_MASK) == (BAR_BASE & BAR_MASK))`.
- Write commands are 4'b0111 (memory write), 4'b1111 (memory write and invalidate) and 4'b0011 (IO write). Every other command is treated as a read.
- FIFO entry is 72 bits: {bc, be, addr, data}. It holds the full context of one data phase, so the drain side needs no framing.
- `free = DEPTH - count`. `count` is AW+1 bits wide and is always sampled before this cycle's push or pop.
- State machine has three states: IDLE, XFER, TERM.
  - **IDLE**, with `req_i` low or no claim: status WAIT, stay in IDLE.
  - **IDLE**, claimed, read command: status RETRY, go to TERM.
  - **IDLE**, claimed, write command, `free == 0`: status RETRY, go to TERM.
  - **IDLE**, claimed, write command, otherwise: status WAIT, go to XFER.
  - **XFER**, `rdy_i` low: status WAIT.
  - **XFER**, `rdy_i` high: evaluate in this priority order.
    1. No claim (burst has left the BAR): status TABORT, no push, go to TERM.
    2. `free == 0`: status DISCONNECT_WO_DATA, no push, go to TERM. This is defensive only; the FIFO cannot be full in XFER.
    3. Push the phase, then choose the status:
       - `last_i` high: TRANSFERED, go to TERM.
       - `free == 1`: DISCONNECT_W_DATA, go to TERM.
       - IO write (4'b0011): DISCONNECT_W_DATA, go to TERM. IO space allows single transfers only.
       - Otherwise: TRANSFERED, stay in XFER.
  - **XFER**, `req_i` low: go to IDLE, status WAIT.
  - **TERM**: status WAIT until `req_i` is low, then go to IDLE.
- Pop: when `fifo_rd_i` is high and the FIFO is not empty, advance the read pointer.
  - Push and pop on the same edge leave `count` unchanged.
  - A pop does not relieve the disconnect or retry decision made in the same cycle.
- Pointers are AW bits and wrap modulo DEPTH.
- All `fifo_*` data outputs are forced to 0 while `fifo_empty_o` is high.

## Timing
- `status_o` and `addr_claim_o` are combinational from registered state and the current inputs. They are valid in the same cycle as `rdy_i` and `req_i`.
- The target SM samples `status_o` on the rising edge; the push occurs on that same edge.
- The target SM asserts `rdy_i` no earlier than one cycle after `req_i` rises. XFER is always entered before the first data phase.
- Write latency: an entry pushed on edge N is visible at the FIFO head and `fifo_empty_o` falls after edge N.
- Pop: the head advances on the edge where `fifo_rd_i` is sampled high.
- On `reset_in` assertion, immediately and asynchronously:
  - state = IDLE, count = 0, pointers = 0;
  - `fifo_empty_o` = 1, all `fifo_*` data outputs = 0, `status_o` = WAIT.
  - Storage array contents are not reset.
- Reset mid-transaction discards every queued entry. A subsequent `req_i` is decoded fresh from IDLE.

## Test plan
- **Single memory write.** bc 0111, address 32'h1000_0010, data 32'hDEAD_BEEF, be 4'h0, `last_i` high. Required: `addr_claim_o` = 1, status TRANSFERED. Next cycle the head shows {0111, 0, 1000_0010, DEAD_BEEF} and `fifo_empty_o` = 0.
- **Burst filling the FIFO.** DEPTH 8, empty FIFO, 10-phase burst starting at 32'h1000_0000 with +4 per phase. Required: phases 1-7 TRANSFERED, phase 8 DISCONNECT_W_DATA, count = 8. A new write then gets RETRY in its first cycle with no push.
- **Reads and misses.** Claimed read (bc 0110) → RETRY; TERM is held until `req_i` is low; count unchanged. Address 32'h2000_0000 → `addr_claim_o` = 0, status WAIT, state stays IDLE.
- **BAR exit.** Burst at 32'h1000_FFFC then 32'h1001_0000. Required: TRANSFERED, then TABORT. FIFO holds exactly 1 entry.
- **IO write.** bc 0011, 2-phase burst. Required: first phase DISCONNECT_W_DATA, 1 entry pushed. Concurrently, drain with `fifo_rd_i` while pushing and confirm push+pop on one edge keeps `count` constant.
- **Reset mid-burst.** Assert `reset_in` after 3 pushes. Required: `fifo_empty_o` = 1 and `status_o` = WAIT asynchronously. A post-reset write is accepted normally.
